// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer: mult/div FSM states,
// register/bubble constants and the load-use compare helper.
package hazard_sequencer_pkg;

  // Mult/div timer states; ST_BUSY means the unit holds HI/LO in flight.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // $zero never carries a real dependency.
  localparam logic [4:0]  REG_ZERO    = 5'd0;
  // sll $0,$0,0 -- what IF/ID loads on a flush.
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  // Control bits of an ID/EX bubble.
  localparam logic        BUBBLE_CTRL = 1'b0;

  // True when the EX-stage load writes a register the ID-stage instruction reads.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt);
    return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Bundle of hazard inputs and pipeline-control outputs for the sequencer.
// There is no valid/ready handshake here: every input is a level sampled each
// cycle, and every enable/flush output is valid in the same cycle it is produced
// (combinational), with stall_count and md_state registered.
interface hazard_sequencer_if #(
  parameter int PERF_W = 32
);
  import hazard_sequencer_pkg::*;

  logic              ID_EX_memRead;
  logic [4:0]        ID_EX_rt;
  logic [4:0]        IF_ID_rs;
  logic [4:0]        IF_ID_rt;
  logic              ex_branch_taken;
  logic              ex_md_start;
  logic              id_md_op;
  logic              mem_wait;
  logic              perf_clr;

  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_write;
  logic              md_busy;
  logic [PERF_W-1:0] stall_count;
  md_state_e         md_state;

  // Pipeline side: drives hazard sources, consumes enables.
  modport master (
    output ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt, ex_branch_taken,
           ex_md_start, id_md_op, mem_wait, perf_clr,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
           md_busy, stall_count, md_state
  );

  // Sequencer side.
  modport slave (
    input  ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt, ex_branch_taken,
           ex_md_start, id_md_op, mem_wait, perf_clr,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
           md_busy, stall_count, md_state
  );

endinterface

// File: rtl/hazard_sequencer_md_busy_timer.sv
// Mult/div busy timer: after an accepted start, busy stays high for exactly
// MD_LATENCY cycles beginning the next cycle. Starts while busy are ignored.
module md_busy_timer
  import hazard_sequencer_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  output logic      busy,
  output md_state_e dbg_state
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_LATENCY - 1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State and down-counter registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: load on start from RUN, count down freely in BUSY (the unit
  // keeps running through memory freezes), leave BUSY after the zero cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (start) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = LOAD_VAL;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign busy      = (r_state == ST_BUSY);
  assign dbg_state = r_state;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline-control unit for the 5-stage MIPS core. Merges memory wait,
// taken branch, mult/div busy and load-use hazards into per-stage enables and
// flushes, and counts cycles in which the PC was held.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_sequencer_if.slave   bus
);

  logic              w_load_use;
  logic              w_md_busy;
  logic              w_md_hazard;
  logic              w_md_accept;
  md_state_e         w_md_state;
  logic              w_pc_write;
  logic              w_if_id_write;
  logic              w_if_id_flush;
  logic              w_id_ex_flush;
  logic              w_ex_mem_write;
  logic [PERF_W-1:0] r_stall_count;

  assign w_load_use  = load_use_hit(bus.ID_EX_memRead, bus.ID_EX_rt, bus.IF_ID_rs, bus.IF_ID_rt);
  assign w_md_hazard = w_md_busy && bus.id_md_op;
  // A frozen pipeline does not advance EX, so the start is re-presented later.
  assign w_md_accept = bus.ex_md_start && !bus.mem_wait;

  md_busy_timer #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_md_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_md_accept),
    .busy      (w_md_busy),
    .dbg_state (w_md_state)
  );

  // Priority mux: reset, then memory freeze, branch flush, stall, normal flow.
  // A taken branch beats load-use because the stalled instruction is discarded.
  always_comb begin
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_write = 1'b1;
    if (!rst_n) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_ex_mem_write = 1'b0;
    end else if (bus.mem_wait) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_ex_mem_write = 1'b0;
    end else if (bus.ex_branch_taken) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
    end else if (w_md_hazard || w_load_use) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_flush  = 1'b1;
    end
  end

  // Saturating count of PC-hold cycles; clear takes precedence over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (bus.perf_clr) begin
      r_stall_count <= '0;
    end else if (!w_pc_write && (r_stall_count != {PERF_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.ex_mem_write = w_ex_mem_write;
  assign bus.md_busy      = w_md_busy;
  assign bus.md_state     = w_md_state;
  assign bus.stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer with MD_LATENCY=4 and a 4-bit stall counter.
module tb_hazard_sequencer;
  import hazard_sequencer_pkg::*;

  localparam int MD_LAT = 4;
  localparam int PW     = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hazard_sequencer_if #(.PERF_W(PW)) bus ();

  hazard_sequencer #(
    .MD_LATENCY (MD_LAT),
    .CNT_W      (2),
    .PERF_W     (PW)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector record: inputs and expected {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write}
  typedef struct {
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       mdop;
    logic       mw;
    logic [4:0] exp_ctrl;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [4:0] ctrl_now();
    return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_write};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.ID_EX_memRead   = 1'b0;
    bus.ID_EX_rt        = 5'd0;
    bus.IF_ID_rs        = 5'd0;
    bus.IF_ID_rt        = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_md_start     = 1'b0;
    bus.id_md_op        = 1'b0;
    bus.mem_wait        = 1'b0;
    bus.perf_clr        = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One cycle with perf_clr asserted, leaving the counter at zero.
  task automatic clear_perf();
    tick();
    idle();
    bus.perf_clr = 1'b1;
    tick();
    bus.perf_clr = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    // Hand-computed vectors
    vecs[0]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00011}; // load-use on rs
    vecs[1]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11001}; // rt=$zero: no stall
    vecs[2]  = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 5'b00011}; // load-use on rt
    vecs[3]  = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 5'b11001}; // not a load
    vecs[4]  = '{1'b1, 5'd9, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 5'b11001}; // no register match
    vecs[5]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'b11111}; // branch beats load-use
    vecs[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b11111}; // branch alone
    vecs[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b00000}; // mem_wait alone
    vecs[8]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'b00000}; // mem_wait over load-use
    vecs[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'b00000}; // mem_wait over branch
    vecs[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11001}; // md op, unit idle

    // Reset state
    rst_n = 1'b0;
    idle();
    #3;
    chk("reset_ctrl", 32'(ctrl_now()), 32'b00110);
    chk("reset_md_busy", 32'(bus.md_busy), 32'd0);
    chk("reset_stall_count", 32'(bus.stall_count), 32'd0);
    tick();
    rst_n = 1'b1;

    // Table-driven combinational priority
    begin
      int exp_stall;
      exp_stall = 0;
      for (int i = 0; i < 11; i++) begin
        tick();
        idle();
        bus.ID_EX_memRead   = vecs[i].mr;
        bus.ID_EX_rt        = vecs[i].ex_rt;
        bus.IF_ID_rs        = vecs[i].rs;
        bus.IF_ID_rt        = vecs[i].rt;
        bus.ex_branch_taken = vecs[i].br;
        bus.id_md_op        = vecs[i].mdop;
        bus.mem_wait        = vecs[i].mw;
        #1;
        chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_now()), 32'(vecs[i].exp_ctrl));
        if (vecs[i].exp_ctrl[4] == 1'b0) exp_stall++;
      end
      tick();
      idle();
      #1;
      chk("vec_stall_count", 32'(bus.stall_count), 32'(exp_stall));
    end

    // T3: md_busy window, md hazard stall, restart ignored while busy
    clear_perf();
    begin
      logic [5:0] exp_busy;
      logic [5:0] exp_pc;
      exp_busy = 6'b011110; // bit c = cycle c
      exp_pc   = 6'b100011;
      for (int c = 0; c < 6; c++) begin
        if (c > 0) tick();
        bus.ex_md_start = (c == 0) || (c == 2);
        bus.id_md_op    = (c >= 2);
        #1;
        chk($sformatf("t3_busy_c%0d", c), 32'(bus.md_busy), 32'(exp_busy[c]));
        chk($sformatf("t3_pc_write_c%0d", c), 32'(bus.pc_write), 32'(exp_pc[c]));
        if (c >= 2 && c <= 4)
          chk($sformatf("t3_id_ex_flush_c%0d", c), 32'(bus.id_ex_flush), 32'd1);
      end
      tick();
      idle();
      #1;
      chk("t3_stall_count", 32'(bus.stall_count), 32'd3);
    end

    // T5: freeze with a pending branch and a pending md start
    clear_perf();
    for (int c = 0; c < 3; c++) begin
      bus.mem_wait        = 1'b1;
      bus.ex_branch_taken = 1'b1;
      bus.ex_md_start     = 1'b1;
      #1;
      chk($sformatf("t5_freeze_ctrl_c%0d", c), 32'(ctrl_now()), 32'b00000);
      chk($sformatf("t5_freeze_busy_c%0d", c), 32'(bus.md_busy), 32'd0);
      tick();
    end
    bus.mem_wait = 1'b0;
    #1;
    chk("t5_flush_ctrl", 32'(ctrl_now()), 32'b11111);
    tick();
    idle();
    #1;
    chk("t5_stall_count", 32'(bus.stall_count), 32'd3);
    chk("t5_start_accepted", 32'(bus.md_busy), 32'd1);
    // Timer keeps counting through a freeze: busy cycles 1-4 regardless.
    bus.mem_wait = 1'b1;
    tick();
    chk("t5_busy_c2_frozen", 32'(bus.md_busy), 32'd1);
    tick();
    bus.mem_wait = 1'b0;
    tick();
    #1;
    chk("t5_busy_c4", 32'(bus.md_busy), 32'd1);
    tick();
    #1;
    chk("t5_busy_c5_done", 32'(bus.md_busy), 32'd0);

    // T6: asynchronous reset in the middle of BUSY
    tick();
    bus.ex_md_start = 1'b1;
    tick();
    bus.ex_md_start = 1'b0;
    bus.mem_wait    = 1'b1;
    tick();
    bus.mem_wait = 1'b0;
    #1;
    chk("t6_busy_before", 32'(bus.md_busy), 32'd1);
    chk("t6_state_before", 32'(bus.md_state), 32'(ST_BUSY));
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_async", 32'(bus.md_busy), 32'd0);
    chk("t6_stall_async", 32'(bus.stall_count), 32'd0);
    chk("t6_ctrl_async", 32'(ctrl_now()), 32'b00110);
    tick();
    rst_n = 1'b1;
    bus.ex_md_start = 1'b1;
    tick();
    bus.ex_md_start = 1'b0;
    #1;
    chk("t6_restart_busy", 32'(bus.md_busy), 32'd1);
    for (int c = 0; c < 4; c++) tick();
    #1;
    chk("t6_restart_done", 32'(bus.md_busy), 32'd0);

    // Saturation and perf_clr precedence
    clear_perf();
    bus.mem_wait = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    idle();
    #1;
    chk("sat_stall_count", 32'(bus.stall_count), 32'd15);
    bus.mem_wait = 1'b1;
    bus.perf_clr = 1'b1;
    tick();
    idle();
    #1;
    chk("clr_beats_inc", 32'(bus.stall_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
